unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch port and its data (load/store) port, for the multi-cycle version of the RISC-V core.
- Arbitrates between the two requesters using 2-way round robin.
- Issues exactly one memory access per granted request.
- Returns read data or a write acknowledgment to the owner after a fixed memory latency.
- Drives a stall signal that freezes the PC and pipeline while either port is waiting.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, level; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch data
d_req  in  1  data request, level; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  load data valid, or store complete (1-cycle pulse)
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe (1 cycle per access)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
cpu_stall  out  1  freeze core

Behaviour:
Reset (asynchronous, any time):
- State goes to IDLE; cnt = 0; last_owner = OWN_IF, so data wins the first tie.
- All registered outputs clear to 0: mem_en, mem_we, mem_addr, mem_wdata, gnts, rvalids.
- Any in-flight access is abandoned; no rvalid is produced for it.

States:
- IDLE: if any req is high, grant the winner.
  - x_gnt is asserted combinationally in this cycle.
  - Latch owner, addr, we and wdata. For fetch, we = 0 and wdata = 0.
  - Next state is ISSUE. With no request, stay in IDLE.
- ISSUE: mem_en = 1; mem_we/mem_addr/mem_wdata come from the latches.
  - Load cnt = MEM_LAT-1.
  - Next state is WAIT. If MEM_LAT == 1, next state is DONE.
- WAIT: decrement cnt. When cnt reaches 1, next state is DONE.
- DONE: this cycle is exactly MEM_LAT cycles after the ISSUE cycle.
  - Pulse owner_rvalid. owner_rdata = mem_rdata (combinational pass-through).
  - For a store, d_rvalid still pulses; d_rdata is a don't-care.
  - Arbitrate in this same cycle, exactly as in IDLE (back-to-back). With no request, go to IDLE.

Arbitration:
- Only one requester high: it wins.
- Both high: the one that is not last_owner wins.
- last_owner updates on every grant.

Request rules:
- A req that drops before its gnt is withdrawn. This is legal and issues no access.
- req is ignored in ISSUE and WAIT.
- A req that is high in an arbitration cycle (IDLE or DONE) is a new request. Requesters drop req after gnt unless they are issuing a new one.

Other output rules:
- mem_en is high only in ISSUE.
- mem_addr, mem_wdata and mem_we hold their latched values until the next grant.
- Non-owner rdata outputs are 0.
- cpu_stall = (state != IDLE && state != DONE) | (if_req & ~if_gnt) | (d_req & ~d_gnt). It is combinational.

Throughput and latency:
- One access per MEM_LAT+1 cycles.
- gnt to rvalid = MEM_LAT+1 cycles.

Decomposition:
- Package mips_mem_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - owner enum {OWN_IF, OWN_D}
  - localparam CNT_W = 4
- Sub-module rr_arbiter2 covers the 2-request round-robin pick and the last_owner register.
  - Ports: clk, rst, req[1:0], advance, gnt[1:0].
- The top module holds the FSM, counter, latches and output muxing.

Test Plan:
- Fetch alone, MEM_LAT=2, if_req=1 with if_addr=0x40 at cycle 0:
  - if_gnt at cycle 0; mem_en=1 with mem_addr=0x40 and mem_we=0 at cycle 1.
  - if_rvalid at cycle 3 with if_rdata = mem_rdata (0xDEADBEEF).
- Simultaneous if_req and d_req after reset:
  - d_gnt first; if_gnt in d's DONE cycle; mem_en pulses 3 cycles apart.
  - Both held continuously: grants alternate D, IF, D, IF.
- Store: d_we=1, d_addr=0x100, d_wdata=0x1234:
  - mem_en with mem_we=1, mem_addr=0x100, mem_wdata=0x1234.
  - d_rvalid 2 cycles later; if_rvalid stays 0.
- MEM_LAT=1 back-to-back fetches to 0x0 and 0x4: mem_en at cycles 1 and 3; if_rvalid at cycles 2 and 4.
- Reset mid-op: rst pulsed in WAIT:
  - Outputs clear immediately (async); no rvalid is produced.
  - After reset, a pending d_req is granted in the first cycle.
- Withdrawn request: d_req high for 1 cycle while a fetch is in WAIT, dropped before DONE → no d_gnt and no mem_en for it; cpu_stall stays 1 until fetch DONE.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
//
// Contents:
//   state_t - access FSM states (IDLE, ISSUE, WAIT, DONE)
//   owner_t - which core port owns the current access (OWN_IF, OWN_D)
//   CNT_W   - width of the latency down-counter (covers MEM_LAT up to 15)
//   REQ_IF / REQ_D - bit positions of the two requesters in req/gnt vectors
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int CNT_W  = 4;
    localparam int REQ_IF = 0;
    localparam int REQ_D  = 1;

endpackage : mips_mem_pkg

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//
// Picks one of two requesters. A lone requester always wins; on a tie the
// requester that did not own the previous grant wins. The last owner is
// remembered across cycles and updated on every grant.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset (last owner -> OWN_IF)
//   req[1:0] - request vector, bit REQ_IF = fetch, bit REQ_D = data
//   advance  - this is an arbitration cycle; a grant updates the last owner
//   gnt[1:0] - one-hot (or zero) combinational grant
module rr_arbiter2
    import mips_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    owner_t last_owner;

    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (req[REQ_D] && (!req[REQ_IF] || (last_owner == OWN_IF))) begin
            gnt[REQ_D] = 1'b1;
        end else if (req[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end
    end

    // After reset the fetch port counts as last owner, so data wins the
    // first tie.
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_IF;
        end else if (advance && (gnt != 2'b00)) begin
            last_owner <= gnt[REQ_D] ? OWN_D : OWN_IF;
        end
    end

endmodule : rr_arbiter2

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter for the multi-cycle RISC-V core.
//
// Shares one single-port memory between the instruction-fetch port and the
// load/store port. Each granted request produces exactly one memory access;
// read data (or a store completion) is returned to the owning port exactly
// MEM_LAT cycles after the access strobe. Arbitration happens in IDLE and in
// DONE, so a waiting request is granted in the same cycle the previous access
// completes (one access per MEM_LAT+1 cycles).
//
// Parameters:
//   ADDR_W  - address width
//   DATA_W  - data width
//   MEM_LAT - cycles from mem_en to valid mem_rdata, legal range 1..15
//
// Ports:
//   clk, rst                    - clock (rising edge), async active-high reset
//   if_req/if_addr              - fetch request (level, held until if_gnt)
//   if_gnt                      - fetch accepted, combinational 1-cycle pulse
//   if_rvalid/if_rdata          - fetch data return, 1-cycle pulse
//   d_req/d_we/d_addr/d_wdata   - load/store request (level, held until d_gnt)
//   d_gnt                       - data request accepted, 1-cycle pulse
//   d_rvalid/d_rdata            - load data or store completion, 1-cycle pulse
//   mem_en/mem_we/mem_addr/mem_wdata - memory access, mem_en only in ISSUE
//   mem_rdata                   - memory read data, valid MEM_LAT after mem_en
//   cpu_stall                   - freeze PC/pipeline while a port is waiting
module unified_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              cpu_stall
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    owner_t             owner_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic               arb_en;
    logic [1:0]         arb_req;
    logic [1:0]         arb_gnt;
    logic               grant;
    logic               done;

    // Requests are only looked at in arbitration cycles. Holding reset also
    // blocks arbitration so no grant pulses while the block is held in reset.
    assign arb_en  = ((state_q == IDLE) || (state_q == DONE)) && !rst;
    assign arb_req = {d_req, if_req} & {2{arb_en}};
    assign grant   = (arb_gnt != 2'b00);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (arb_en),
        .gnt     (arb_gnt)
    );

    // ------------------------------------------------------------------
    // Access FSM: next state and counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant) state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = (MEM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                // cnt holds the remaining WAIT cycles including this one.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                state_d = grant ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Request latches: captured on every grant, held until the next one,
    // and driven straight onto the memory address/data/write lines.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            if (arb_gnt[REQ_D]) begin
                owner_q <= OWN_D;
                we_q    <= d_we;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end else begin
                owner_q <= OWN_IF;
                we_q    <= 1'b0;
                addr_q  <= if_addr;
                wdata_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_gnt    = arb_gnt[REQ_IF];
    assign d_gnt     = arb_gnt[REQ_D];

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // DONE is the cycle mem_rdata is valid; pass it through to the owner
    // only, the other port sees zero.
    assign done      = (state_q == DONE);
    assign if_rvalid = done && (owner_q == OWN_IF);
    assign d_rvalid  = done && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

    // Stall while an access is in flight, or while any request is still
    // waiting for its grant.
    assign cpu_stall = ((state_q != IDLE) && (state_q != DONE))
                     | (if_req & ~if_gnt)
                     | (d_req  & ~d_gnt);

endmodule : unified_mem_arbiter

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter.
// Instance dut uses MEM_LAT=2, instance dut1 uses MEM_LAT=1. Each has a small
// memory model that returns a fixed word per address MEM_LAT cycles after
// mem_en, and a junk word in every other cycle.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_unified_mem_arbiter;

    localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;

    // MEM_LAT = 2 instance
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall;
    logic [31:0] pipe0, pipe1;

    // MEM_LAT = 1 instance
    logic        if_req_1;
    logic [31:0] if_addr_1;
    logic        if_gnt_1, if_rvalid_1;
    logic [31:0] if_rdata_1;
    logic        d_req_1, d_we_1;
    logic [31:0] d_addr_1, d_wdata_1;
    logic        d_gnt_1, d_rvalid_1;
    logic [31:0] d_rdata_1;
    logic        mem_en_1, mem_we_1;
    logic [31:0] mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        cpu_stall_1;

    int checks;
    int failures;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_stall (cpu_stall)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req_1),
        .if_addr   (if_addr_1),
        .if_gnt    (if_gnt_1),
        .if_rvalid (if_rvalid_1),
        .if_rdata  (if_rdata_1),
        .d_req     (d_req_1),
        .d_we      (d_we_1),
        .d_addr    (d_addr_1),
        .d_wdata   (d_wdata_1),
        .d_gnt     (d_gnt_1),
        .d_rvalid  (d_rvalid_1),
        .d_rdata   (d_rdata_1),
        .mem_en    (mem_en_1),
        .mem_we    (mem_we_1),
        .mem_addr  (mem_addr_1),
        .mem_wdata (mem_wdata_1),
        .mem_rdata (mem_rdata_1),
        .cpu_stall (cpu_stall_1)
    );

    // Fixed memory contents used by the directed tests.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: rd_word = 32'hDEAD_BEEF;
            32'h0000_0080: rd_word = 32'h3333_4444;
            32'h0000_0200: rd_word = 32'h1111_2222;
            32'h0000_0000: rd_word = 32'h0A0A_0001;
            32'h0000_0004: rd_word = 32'h0A0A_0002;
            default:       rd_word = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory models: data for an access appears MEM_LAT cycles after mem_en.
    always @(posedge clk) begin
        pipe0       <= mem_en ? rd_word(mem_addr) : JUNK;
        pipe1       <= pipe0;
        mem_rdata_1 <= mem_en_1 ? rd_word(mem_addr_1) : JUNK;
    end
    assign mem_rdata = pipe1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        if_req_1 = 1'b0; if_addr_1 = '0;
        d_req_1 = 1'b0; d_we_1 = 1'b0; d_addr_1 = '0; d_wdata_1 = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if ({mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({cpu_stall, mem_en_1, if_gnt_1, if_rvalid_1} !== 4'b0) begin
            failures++;
            $display("FAIL reset_misc: got %b expected 0000",
                     {cpu_stall, mem_en_1, if_gnt_1, if_rvalid_1});
        end
        next_cycle();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_fetch;
        // cycle 0
        if_req = 1'b1; if_addr = 32'h40;
        sample();
        checks++;
        if ({if_gnt, d_gnt, cpu_stall} !== 3'b100) begin
            failures++;
            $display("FAIL fetch_gnt: got gnt/dgnt/stall=%b expected 100", {if_gnt, d_gnt, cpu_stall});
        end
        // cycle 1: ISSUE
        next_cycle(); if_req = 1'b0; if_addr = '0;
        sample();
        checks++;
        if ({mem_en, mem_we, cpu_stall} !== 3'b101 || mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL fetch_issue: got en/we/stall=%b addr=%h expected 101 addr=00000040",
                     {mem_en, mem_we, cpu_stall}, mem_addr);
        end
        // cycle 2: WAIT
        next_cycle(); sample();
        checks++;
        if ({mem_en, if_rvalid, cpu_stall} !== 3'b001) begin
            failures++;
            $display("FAIL fetch_wait: got en/rvalid/stall=%b expected 001", {mem_en, if_rvalid, cpu_stall});
        end
        // cycle 3: DONE
        next_cycle(); sample();
        checks++;
        if ({if_rvalid, d_rvalid, cpu_stall} !== 3'b100 || if_rdata !== 32'hDEAD_BEEF || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_done: got rv=%b rdata=%h drdata=%h expected 100 DEADBEEF 0",
                     {if_rvalid, d_rvalid, cpu_stall}, if_rdata, d_rdata);
        end
        // cycle 4: back in IDLE, address held
        next_cycle(); sample();
        checks++;
        if ({if_rvalid, mem_en, cpu_stall} !== 3'b000 || mem_addr !== 32'h40 || if_rdata !== 32'h0) begin
            failures++;
            $display("FAIL fetch_idle: got rv/en/stall=%b addr=%h rdata=%h expected 000 00000040 0",
                     {if_rvalid, mem_en, cpu_stall}, mem_addr, if_rdata);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_tie;
        // Per-cycle expectations, bit c = cycle c. Both requests held for
        // cycles 0..11 and dropped in cycle 12.
        logic [12:0] e_dg, e_ig, e_en, e_drv, e_irv, e_st;
        e_dg  = 13'h0041;   // d_gnt     at 0, 6
        e_ig  = 13'h0208;   // if_gnt    at 3, 9
        e_en  = 13'h0492;   // mem_en    at 1, 4, 7, 10
        e_drv = 13'h0208;   // d_rvalid  at 3, 9
        e_irv = 13'h1040;   // if_rvalid at 6, 12
        e_st  = 13'h0FFF;   // stall     at 0..11
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 13; c++) begin
            if (c == 12) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            sample();
            checks++;
            if ({d_gnt, if_gnt, mem_en, d_rvalid, if_rvalid, cpu_stall} !==
                {e_dg[c], e_ig[c], e_en[c], e_drv[c], e_irv[c], e_st[c]}) begin
                failures++;
                $display("FAIL tie_cycle%0d: got dg/ig/en/drv/irv/st=%b expected %b", c,
                         {d_gnt, if_gnt, mem_en, d_rvalid, if_rvalid, cpu_stall},
                         {e_dg[c], e_ig[c], e_en[c], e_drv[c], e_irv[c], e_st[c]});
            end
            if (e_en[c]) begin
                checks++;
                if (mem_addr !== (((c == 1) || (c == 7)) ? 32'h200 : 32'h80)) begin
                    failures++;
                    $display("FAIL tie_addr%0d: got %h", c, mem_addr);
                end
            end
            if (e_drv[c]) begin
                checks++;
                if (d_rdata !== 32'h1111_2222 || if_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL tie_drdata%0d: got d=%h if=%h expected 11112222 0", c, d_rdata, if_rdata);
                end
            end
            if (e_irv[c]) begin
                checks++;
                if (if_rdata !== 32'h3333_4444 || d_rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL tie_irdata%0d: got if=%h d=%h expected 33334444 0", c, if_rdata, d_rdata);
                end
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_store;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234;
        sample();
        checks++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL store_gnt: got dg/ig=%b expected 10", {d_gnt, if_gnt});
        end
        next_cycle(); d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        sample();
        checks++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234) begin
            failures++;
            $display("FAIL store_issue: got en/we=%b addr=%h wdata=%h expected 11 100 1234",
                     {mem_en, mem_we}, mem_addr, mem_wdata);
        end
        next_cycle(); sample();
        checks++;
        if ({d_rvalid, if_rvalid, mem_en} !== 3'b000) begin
            failures++;
            $display("FAIL store_wait: got drv/irv/en=%b expected 000", {d_rvalid, if_rvalid, mem_en});
        end
        next_cycle(); sample();
        checks++;
        if ({d_rvalid, if_rvalid} !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL store_done: got drv/irv=%b we=%b addr=%h expected 10 1 100",
                     {d_rvalid, if_rvalid}, mem_we, mem_addr);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_lat1_back_to_back;
        logic [4:0] e_g, e_en, e_rv, e_st;
        e_g  = 5'b00101;    // if_gnt    at 0, 2
        e_en = 5'b01010;    // mem_en    at 1, 3
        e_rv = 5'b10100;    // if_rvalid at 2, 4
        e_st = 5'b01010;    // stall     in ISSUE only
        do_reset();
        for (int c = 0; c < 5; c++) begin
            // Request held into ISSUE (cycle 1) must be ignored there.
            if_req_1  = (c < 3);
            if_addr_1 = (c == 0) ? 32'h0 : 32'h4;
            sample();
            checks++;
            if ({if_gnt_1, mem_en_1, if_rvalid_1, cpu_stall_1} !== {e_g[c], e_en[c], e_rv[c], e_st[c]}) begin
                failures++;
                $display("FAIL lat1_cycle%0d: got g/en/rv/st=%b expected %b", c,
                         {if_gnt_1, mem_en_1, if_rvalid_1, cpu_stall_1},
                         {e_g[c], e_en[c], e_rv[c], e_st[c]});
            end
            if (e_en[c]) begin
                checks++;
                if (mem_addr_1 !== ((c == 1) ? 32'h0 : 32'h4)) begin
                    failures++;
                    $display("FAIL lat1_addr%0d: got %h", c, mem_addr_1);
                end
            end
            if (e_rv[c]) begin
                checks++;
                if (if_rdata_1 !== ((c == 2) ? 32'h0A0A_0001 : 32'h0A0A_0002)) begin
                    failures++;
                    $display("FAIL lat1_rdata%0d: got %h", c, if_rdata_1);
                end
            end
            next_cycle();
        end
        if_req_1 = 1'b0; if_addr_1 = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_op;
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        sample();
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rmid_gnt: got %b expected 1", if_gnt);
        end
        next_cycle(); if_req = 1'b0; if_addr = '0;
        // cycle 2: WAIT, data request arrives and must be ignored here
        next_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        sample();
        checks++;
        if ({d_gnt, mem_en, if_rvalid, cpu_stall} !== 4'b0001 || mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL rmid_wait: got dg/en/rv/st=%b addr=%h expected 0001 40",
                     {d_gnt, mem_en, if_rvalid, cpu_stall}, mem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_en, mem_we, d_gnt, if_gnt, if_rvalid, d_rvalid} !== 6'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rmid_async_clear: got ctrl=%b addr=%h expected 000000 0",
                     {mem_en, mem_we, d_gnt, if_gnt, if_rvalid, d_rvalid}, mem_addr);
        end
        // cycle 3: reset released; would have been the fetch DONE cycle
        next_cycle(); rst = 1'b0;
        sample();
        checks++;
        if ({d_gnt, if_gnt, if_rvalid, mem_en} !== 4'b1000) begin
            failures++;
            $display("FAIL rmid_first_gnt: got dg/ig/rv/en=%b expected 1000",
                     {d_gnt, if_gnt, if_rvalid, mem_en});
        end
        next_cycle(); d_req = 1'b0; d_addr = '0;
        // cycles 4..7: load runs, the abandoned fetch never returns
        for (int c = 4; c < 8; c++) begin
            sample();
            checks++;
            if ({if_rvalid, d_rvalid, mem_en} !== {1'b0, (c == 6), (c == 4)}) begin
                failures++;
                $display("FAIL rmid_cycle%0d: got irv/drv/en=%b expected %b", c,
                         {if_rvalid, d_rvalid, mem_en}, {1'b0, (c == 6), (c == 4)});
            end
            if (c == 6) begin
                checks++;
                if (d_rdata !== 32'h3333_4444) begin
                    failures++;
                    $display("FAIL rmid_rdata: got %h expected 33334444", d_rdata);
                end
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_withdrawn;
        if_req = 1'b1; if_addr = 32'h40;
        sample();
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL wd_gnt: got %b expected 1", if_gnt);
        end
        next_cycle(); if_req = 1'b0; if_addr = '0;
        next_cycle(); d_req = 1'b1; d_addr = 32'h200;    // WAIT
        sample();
        checks++;
        if ({d_gnt, cpu_stall} !== 2'b01) begin
            failures++;
            $display("FAIL wd_wait: got dg/st=%b expected 01", {d_gnt, cpu_stall});
        end
        next_cycle(); d_req = 1'b0; d_addr = '0;          // DONE
        sample();
        checks++;
        if ({if_rvalid, d_gnt, cpu_stall} !== 3'b100 || if_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wd_done: got irv/dg/st=%b rdata=%h expected 100 DEADBEEF",
                     {if_rvalid, d_gnt, cpu_stall}, if_rdata);
        end
        for (int c = 4; c < 6; c++) begin
            next_cycle(); sample();
            checks++;
            if ({mem_en, d_gnt, d_rvalid, cpu_stall} !== 4'b0000) begin
                failures++;
                $display("FAIL wd_idle%0d: got en/dg/drv/st=%b expected 0000", c,
                         {mem_en, d_gnt, d_rvalid, cpu_stall});
            end
        end
        next_cycle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_lat1_back_to_back();
        test_reset_mid_op();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_unified_mem_arbiter
